// File: rtl/mem_bus_sched.sv
// rtl/mem_bus_sched.sv - miss-fill read / write-back buffer scheduler for a single memory bus
// Optional store-to-load forwarding from the write-back FIFO under `WB_FORWARD_EN.
module mem_bus_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic [7:0] rd_address,
  output logic       rd_grant,
  output logic [7:0] rd_data,
  output logic       rd_done,
  input  logic       wb_push,
  input  logic [7:0] wb_address,
  input  logic [7:0] wb_data,
  output logic       wb_full,
  output logic [3:0] wb_count,
  output logic       wb_overflow,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data,
  output logic       bus_access,
  output logic       write_opn_to_bus,
  input  logic       finish,
  input  logic [7:0] out_data_Mem
);

`ifdef WB_FORWARD_EN
  typedef enum logic [1:0] {IDLE, RD_BUS, WR_BUS, FWD} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_BUS, WR_BUS} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] fifo_addr [8];
  logic [7:0] fifo_data [8];
  logic [2:0] head, tail;
  logic [3:0] count, count_nxt;
  logic [7:0] rd_addr_q, rd_addr_nxt;
  logic       push_ok, pop, match, rd_go;
  logic       grant_nxt, done_nxt, bus_nxt, wr_nxt;
  logic [7:0] rd_data_nxt, maddr_nxt, mdata_nxt;
`ifdef WB_FORWARD_EN
  logic [7:0] fwd_data_q, fwd_nxt, match_data;
`endif

  assign wb_count = count;
  assign push_ok  = wb_push & ~wb_full;
  assign pop      = (state == WR_BUS) & finish;
  // rd_done high means the requester has not yet had a cycle to drop rd_req
  assign rd_go    = rd_req & ~rd_done;

  // Ascending scan so the last hit is the youngest valid entry
  always_comb begin
    match = 1'b0;
`ifdef WB_FORWARD_EN
    match_data = 8'h00;
`endif
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < count) && (fifo_addr[head + 3'(i)] == rd_address)) begin
        match = 1'b1;
`ifdef WB_FORWARD_EN
        match_data = fifo_data[head + 3'(i)];
`endif
      end
    end
  end

  always_comb begin
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 4'd1;
      2'b01:   count_nxt = count - 4'd1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = 1'b0;
    done_nxt    = 1'b0;
    rd_data_nxt = rd_data;
    rd_addr_nxt = rd_addr_q;
    bus_nxt     = 1'b0;
    wr_nxt      = 1'b0;
    maddr_nxt   = 8'h00;
    mdata_nxt   = 8'h00;
`ifdef WB_FORWARD_EN
    fwd_nxt     = fwd_data_q;
`endif
    case (state)
      IDLE: begin
        if (wb_full) begin
          state_nxt = WR_BUS;
        end else if (rd_go && match) begin
`ifdef WB_FORWARD_EN
          state_nxt = FWD;
          grant_nxt = 1'b1;
          fwd_nxt   = match_data;
`else
          state_nxt = WR_BUS;
`endif
        end else if (rd_go) begin
          state_nxt   = RD_BUS;
          grant_nxt   = 1'b1;
          rd_addr_nxt = rd_address;
        end else if (count != 4'd0) begin
          state_nxt = WR_BUS;
        end
      end
      RD_BUS: begin
        if (finish) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          rd_data_nxt = out_data_Mem;
        end
      end
      WR_BUS: begin
        if (finish) state_nxt = IDLE;
      end
`ifdef WB_FORWARD_EN
      FWD: begin
        state_nxt   = IDLE;
        done_nxt    = 1'b1;
        rd_data_nxt = fwd_data_q;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are registered from the state being entered
    case (state_nxt)
      RD_BUS: begin
        bus_nxt   = 1'b1;
        maddr_nxt = rd_addr_nxt;
      end
      WR_BUS: begin
        bus_nxt   = 1'b1;
        wr_nxt    = 1'b1;
        maddr_nxt = fifo_addr[head];
        mdata_nxt = fifo_data[head];
      end
      default: bus_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[tail] <= wb_address;
      fifo_data[tail] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      head             <= 3'd0;
      tail             <= 3'd0;
      count            <= 4'd0;
      wb_full          <= 1'b0;
      wb_overflow      <= 1'b0;
      rd_addr_q        <= 8'h00;
      rd_grant         <= 1'b0;
      rd_done          <= 1'b0;
      rd_data          <= 8'h00;
      bus_access       <= 1'b0;
      write_opn_to_bus <= 1'b0;
      mem_address      <= 8'h00;
      mem_data         <= 8'h00;
`ifdef WB_FORWARD_EN
      fwd_data_q       <= 8'h00;
`endif
    end else begin
      state            <= state_nxt;
      if (push_ok) tail <= tail + 3'd1;
      if (pop) head <= head + 3'd1;
      count            <= count_nxt;
      wb_full          <= (count_nxt == 4'd8);
      if (wb_push && wb_full) wb_overflow <= 1'b1;
      rd_addr_q        <= rd_addr_nxt;
      rd_grant         <= grant_nxt;
      rd_done          <= done_nxt;
      rd_data          <= rd_data_nxt;
      bus_access       <= bus_nxt;
      write_opn_to_bus <= wr_nxt;
      mem_address      <= maddr_nxt;
      mem_data         <= mdata_nxt;
`ifdef WB_FORWARD_EN
      fwd_data_q       <= fwd_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_sched.sv
// tb/tb_mem_bus_sched.sv - directed scenarios plus random traffic against a queue-based model
// Model follows `WB_FORWARD_EN the same way as the design.
module tb_mem_bus_sched;
  logic       clk, rst, rd_req, wb_push, finish;
  logic [7:0] rd_address, wb_address, wb_data, out_data_Mem;
  logic       rd_grant, rd_done, wb_full, wb_overflow, bus_access, write_opn_to_bus;
  logic [7:0] rd_data, mem_address, mem_data;
  logic [3:0] wb_count;

  mem_bus_sched dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_address(rd_address),
    .rd_grant(rd_grant), .rd_data(rd_data), .rd_done(rd_done),
    .wb_push(wb_push), .wb_address(wb_address), .wb_data(wb_data),
    .wb_full(wb_full), .wb_count(wb_count), .wb_overflow(wb_overflow),
    .mem_address(mem_address), .mem_data(mem_data), .bus_access(bus_access),
    .write_opn_to_bus(write_opn_to_bus), .finish(finish), .out_data_Mem(out_data_Mem)
  );

  localparam int J_NONE = 0, J_RD = 1, J_WR = 2, J_FWD = 3;

  int          n_vec, n_err, n_done, fin_wait;
  bit          chk_on, auto_mem, got;
  logic [15:0] mq[$];
  logic [16:0] blog[$];
  int          m_job;
  logic [7:0]  m_raddr, m_fdata, dat;
  logic        e_grant, e_done, e_ovf;
  logic [7:0]  e_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: pending work is a queue of {addr,data}; one bus job at a time
  task automatic model_step();
    bit         full, hit, pop;
    logic [7:0] hd;
    if (rst && finish && bus_access) blog.push_back({write_opn_to_bus, mem_address, mem_data});
    if (!rst) begin
      mq.delete();
      m_job = J_NONE; e_grant = 0; e_done = 0; e_data = 0; e_ovf = 0;
    end else begin
      full = (mq.size() == 8);
      pop = 0; hit = 0; hd = 8'h00;
      e_grant = 0; e_done = 0;
      foreach (mq[i]) if (mq[i][15:8] == rd_address) begin hit = 1; hd = mq[i][7:0]; end
      case (m_job)
        J_NONE: begin
          if (full) m_job = J_WR;
          else if (rd_req && hit) begin
`ifdef WB_FORWARD_EN
            m_job = J_FWD; e_grant = 1; m_fdata = hd;
`else
            m_job = J_WR;
`endif
          end else if (rd_req) begin
            m_job = J_RD; e_grant = 1; m_raddr = rd_address;
          end else if (mq.size() > 0) m_job = J_WR;
        end
        J_RD:  if (finish) begin e_done = 1; e_data = out_data_Mem; m_job = J_NONE; end
        J_WR:  if (finish) begin pop = 1; m_job = J_NONE; end
        default: begin e_done = 1; e_data = m_fdata; m_job = J_NONE; end
      endcase
      if (pop) mq.delete(0);
      if (wb_push) begin
        if (!full) mq.push_back({wb_address, wb_data});
        else e_ovf = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (rd_done) n_done++;
        chk("rd_grant", rd_grant, e_grant);
        chk("rd_done", rd_done, e_done);
        if (e_done) chk("rd_data", rd_data, e_data);
        chk("wb_count", wb_count, mq.size());
        chk("wb_full", wb_full, mq.size() == 8);
        chk("wb_overflow", wb_overflow, e_ovf);
        chk("bus_access", bus_access, (m_job == J_RD) || (m_job == J_WR));
        if (m_job == J_RD) begin
          chk("rd_wr_flag", write_opn_to_bus, 0);
          chk("rd_mem_addr", mem_address, m_raddr);
        end
        if (m_job == J_WR) begin
          chk("wr_wr_flag", write_opn_to_bus, 1);
          chk("wr_mem_addr", mem_address, mq[0][15:8]);
          chk("wr_mem_data", mem_data, mq[0][7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    if (rd_req && rd_done) rd_req = 0;
    if (auto_mem) begin
      if (bus_access && !finish) begin
        if (fin_wait == 0) begin finish = 1; out_data_Mem = 8'($urandom); end
        else fin_wait--;
      end else begin
        finish = !bus_access && ($urandom_range(0, 7) == 0);
        out_data_Mem = 8'($urandom);
        fin_wait = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic do_reset();
    rst = 0; rd_req = 0; wb_push = 0; finish = 0; auto_mem = 0;
    tick(); tick();
    rst = 1;
    blog.delete();
    n_done = 0;
  endtask

  task automatic run_until_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (wb_count == 0) && !bus_access && !rd_req;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_done = 0; fin_wait = 0; chk_on = 0; auto_mem = 0;
    rst = 0; rd_req = 0; wb_push = 0; finish = 0;
    rd_address = 0; wb_address = 0; wb_data = 0; out_data_Mem = 0;
    do_reset();
    chk_on = 1;
    chk("reset_count", wb_count, 0);
    chk("reset_bus", bus_access, 0);
    chk("reset_ovf", wb_overflow, 0);
    chk("reset_full", wb_full, 0);

    // Plain read miss with a 3-cycle memory
    rd_req = 1; rd_address = 8'h2A;
    tick();
    chk("s1_grant", rd_grant, 1);
    chk("s1_bus", {bus_access, write_opn_to_bus, mem_address}, {2'b10, 8'h2A});
    tick(); tick();
    finish = 1; out_data_Mem = 8'h5C;
    tick();
    finish = 0;
    chk("s1_done", rd_done, 1);
    chk("s1_data", rd_data, 8'h5C);
    tick(); tick();
    chk("s1_done_count", n_done, 1);
    chk("s1_bus_cycles", blog.size(), 1);
    if (blog.size() > 0) chk("s1_bus_kind", blog[0][16:8], {1'b0, 8'h2A});

    // Overfill: 8 accepted, 9th dropped, drain in order
    do_reset();
    for (int k = 0; k < 8; k++) begin
      wb_push = 1; wb_address = 8'h80 + 8'(k); wb_data = 8'hC0 + 8'(k);
      tick();
    end
    wb_address = 8'h11; wb_data = 8'h22;
    tick();
    wb_push = 0;
    chk("s2_full", wb_full, 1);
    chk("s2_count", wb_count, 8);
    chk("s2_ovf", wb_overflow, 1);
    chk("s2_drain", {bus_access, write_opn_to_bus, mem_address}, {2'b11, 8'h80});
    auto_mem = 1;
    run_until_idle("s2_idle");
    chk("s2_writes", blog.size(), 8);
    for (int k = 0; k < 8 && k < blog.size(); k++)
      chk("s2_order", blog[k], {1'b1, 8'h80 + 8'(k), 8'hC0 + 8'(k)});
    chk("s2_ovf_sticky", wb_overflow, 1);

    // Read hitting a buffered write
    do_reset();
    wb_push = 1; wb_address = 8'h40; wb_data = 8'hAA;
    tick();
    wb_push = 0; rd_req = 1; rd_address = 8'h40; auto_mem = 1;
    got = 0; dat = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (rd_done) begin got = 1; dat = rd_data; end
    end
    chk("s3_done", got, 1);
`ifdef WB_FORWARD_EN
    chk("s3_fwd_data", dat, 8'hAA);
    chk("s3_no_bus", blog.size(), 0);
    run_until_idle("s3_idle");
    chk("s3_bus_cycles", blog.size(), 1);
`else
    chk("s3_bus_cycles", blog.size(), 2);
    if (blog.size() > 1) begin
      chk("s3_write_first", blog[0], {1'b1, 8'h40, 8'hAA});
      chk("s3_read_second", blog[1][16:8], {1'b0, 8'h40});
    end
    run_until_idle("s3_idle");
`endif

    // Non-matching read jumps ahead of buffered writes
    do_reset();
    wb_push = 1; wb_address = 8'h10; wb_data = 8'h01;
    tick();
    wb_address = 8'h11; wb_data = 8'h02; rd_req = 1; rd_address = 8'h07;
    tick();
    wb_push = 0;
    chk("s4_grant", rd_grant, 1);
    chk("s4_bus", {bus_access, write_opn_to_bus, mem_address}, {2'b10, 8'h07});
    chk("s4_count", wb_count, 2);
    auto_mem = 1;
    run_until_idle("s4_idle");
    chk("s4_bus_cycles", blog.size(), 3);
    if (blog.size() > 2) begin
      chk("s4_read", blog[0][16:8], {1'b0, 8'h07});
      chk("s4_wr0", blog[1], {1'b1, 8'h10, 8'h01});
      chk("s4_wr1", blog[2], {1'b1, 8'h11, 8'h02});
    end

    // Reset in the middle of a write, then a stray finish
    do_reset();
    wb_push = 1; wb_address = 8'h33; wb_data = 8'h44;
    tick();
    wb_push = 0;
    tick();
    chk("s5_in_write", {bus_access, write_opn_to_bus}, 2'b11);
    rst = 0;
    tick();
    rst = 1; finish = 1;
    tick();
    finish = 0;
    chk("s5_bus", bus_access, 0);
    chk("s5_count", wb_count, 0);
    tick();
    chk("s5_no_done", n_done, 0);
    chk("s5_no_bus_cycle", blog.size(), 0);

    // Push and pop on the same edge
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wb_push = 1; wb_address = 8'h50 + 8'(k); wb_data = 8'h60 + 8'(k);
      tick();
    end
    chk("s6_count3", wb_count, 3);
    wb_address = 8'h53; wb_data = 8'h63; finish = 1;
    tick();
    wb_push = 0; finish = 0;
    chk("s6_count_same", wb_count, 3);
    tick();
    chk("s6_head_next", {mem_address, mem_data}, {8'h51, 8'h61});
    auto_mem = 1;
    run_until_idle("s6_idle");
    chk("s6_writes", blog.size(), 4);
    for (int k = 0; k < 4 && k < blog.size(); k++)
      chk("s6_order", blog[k], {1'b1, 8'h50 + 8'(k), 8'h60 + 8'(k)});

    // Random traffic on a small address space so reads hit the buffer
    do_reset();
    auto_mem = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      wb_push = ($urandom_range(0, 2) == 0);
      wb_address = 8'($urandom_range(0, 15));
      wb_data = 8'($urandom);
      if (!rd_req && !rd_done && ($urandom_range(0, 5) == 0)) begin
        rd_req = 1;
        rd_address = 8'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 0; rd_req = 0;
      end else rst = 1;
    end
    wb_push = 0; rst = 1;
    run_until_idle("rand_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
